// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit bounds and digit-validity helper.
// Imported by the BCD counter interface, digit cell and top.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic is_bcd(input bcd_digit_t d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_ndigit_counter_if.sv
// Control/data bundle of the N-digit BCD counter.
// master: mode,count,clr,load,din[,limit] out; Q,tc,err in.
// slave: the counter side of the same signals.
// Optional: BCD_MODULO_LIMIT_EN adds the BCD limit bus.
interface bcd_ndigit_counter_if #(
  parameter int NDIGITS = 4
);
  logic                   mode;
  logic                   count;
  logic                   clr;
  logic                   load;
  logic [4*NDIGITS-1:0]   din;
  logic [4*NDIGITS-1:0]   Q;
  logic                   tc;
  logic                   err;
`ifdef BCD_MODULO_LIMIT_EN
  logic [4*NDIGITS-1:0]   limit;

  modport master (
    output mode, count, clr, load, din, limit,
    input  Q, tc, err
  );
  modport slave (
    input  mode, count, clr, load, din, limit,
    output Q, tc, err
  );
`else
  modport master (
    output mode, count, clr, load, din,
    input  Q, tc, err
  );
  modport slave (
    input  mode, count, clr, load, din,
    output Q, tc, err
  );
`endif
endinterface

// File: rtl/bcd_digit_cell.sv
// One BCD digit: clear > load > step, up or down.
// Ports: clk, rst, en_in, mode, clr, load, d_in -> q, at_term.
module bcd_digit_cell
  import bcd_pkg::*;
#(
  parameter int RST_VAL = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_in,
  input  logic       mode,
  input  logic       clr,
  input  logic       load,
  input  bcd_digit_t d_in,
  output bcd_digit_t q,
  output logic       at_term
);

  bcd_digit_t q_nxt;

  // An out-of-range q can only be a glitch; both
  // directions treat it as overflow (0 up, 9 down).
  always_comb begin
    q_nxt = q;
    if (mode) begin
      if (q >= BCD_MAX) q_nxt = BCD_MIN;
      else              q_nxt = q + 4'd1;
    end else begin
      if (q == BCD_MIN || q > BCD_MAX)
        q_nxt = BCD_MAX;
      else
        q_nxt = q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= bcd_digit_t'(RST_VAL);
    else if (clr)   q <= BCD_MIN;
    else if (load)  q <= d_in;
    else if (en_in) q <= q_nxt;
  end

  assign at_term = mode ? (q == BCD_MAX)
                        : (q == BCD_MIN);

endmodule

// File: rtl/bcd_ndigit_counter.sv
// N-digit cascadable BCD up/down counter with load, clear,
// illegal-load flag and terminal count (tc feeds next count).
// Ports: clk, rstn (async, active-high), bus (slave modport).
// Optional: BCD_MODULO_LIMIT_EN adds modulo limit support.
module bcd_ndigit_counter
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int RST_VAL = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  bcd_ndigit_counter_if.slave  bus
);

  localparam int W = 4 * NDIGITS;

  logic [W-1:0]       din_f;
  logic               din_bad;
  logic [W-1:0]       cell_din;
  logic               cell_clr;
  logic               cell_load;
  logic               err_set;
  logic [NDIGITS:0]   en;
  logic [NDIGITS-1:0] at_term;
  logic [W-1:0]       q_w;
  logic               err_q;

  // Illegal load digits become 0 and raise err.
  always_comb begin
    din_f   = '0;
    din_bad = 1'b0;
    for (int k = 0; k < NDIGITS; k++) begin
      if (is_bcd(bus.din[4*k +: 4]))
        din_f[4*k +: 4] = bus.din[4*k +: 4];
      else
        din_bad = 1'b1;
    end
  end

`ifdef BCD_MODULO_LIMIT_EN
  localparam logic [W-1:0] ALL9 = {NDIGITS{BCD_MAX}};

  logic         lim_bad;
  logic [W-1:0] eff_lim;
  logic         ld_over;
  logic [W-1:0] ld_val;
  logic         at_top;
  logic         wrap_up;
  logic         wrap_dn;

  always_comb begin
    lim_bad = 1'b0;
    for (int k = 0; k < NDIGITS; k++)
      if (!is_bcd(bus.limit[4*k +: 4]))
        lim_bad = 1'b1;
  end

  // A broken limit falls back to natural modulo.
  assign eff_lim = lim_bad ? ALL9 : bus.limit;

  // Valid packed BCD compares correctly as binary.
  assign ld_over = din_f > eff_lim;
  assign ld_val  = ld_over ? eff_lim : din_f;
  assign at_top  = bus.Q == eff_lim;

  // Modulo wraps reuse the cells' clear/load paths.
  assign wrap_up = bus.count & bus.mode & at_top;
  assign wrap_dn = bus.count & ~bus.mode
                 & (bus.Q == '0);

  assign cell_clr  = bus.clr
                   | (~bus.load & wrap_up);
  assign cell_load = bus.load | wrap_dn;
  assign cell_din  = bus.load ? ld_val : eff_lim;

  assign err_set = (bus.load & (din_bad | ld_over))
                 | lim_bad;

  assign bus.tc = ~bus.clr & ~bus.load
                & (bus.mode ? (bus.count & at_top)
                            : en[NDIGITS]);
`else
  assign cell_clr  = bus.clr;
  assign cell_load = bus.load;
  assign cell_din  = din_f;
  assign err_set   = bus.load & din_bad;

  // The ripple enable out of the top digit is exactly
  // count & all-digits-terminal.
  assign bus.tc = en[NDIGITS] & ~bus.clr & ~bus.load;
`endif

  assign en[0] = bus.count;

  for (genvar k = 0; k < NDIGITS; k++) begin : g_dig
    bcd_digit_cell #(
      .RST_VAL (RST_VAL)
    ) u_cell (
      .clk     (clk),
      .rst     (rstn),
      .en_in   (en[k]),
      .mode    (bus.mode),
      .clr     (cell_clr),
      .load    (cell_load),
      .d_in    (cell_din[4*k +: 4]),
      .q       (q_w[4*k +: 4]),
      .at_term (at_term[k])
    );
    assign en[k+1] = en[k] & at_term[k];
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn)         err_q <= 1'b0;
    else if (bus.clr) err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign bus.Q   = q_w;
  assign bus.err = err_q;

endmodule

// File: tb/tb_bcd_ndigit_counter.sv
// Directed-vector bench for bcd_ndigit_counter.
// Main 4-digit instance plus two cascaded 2-digit instances.
module tb_bcd_ndigit_counter;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int   nvec = 0;
  int   nerr = 0;
  int   hi_pulses;
  int   lo_pulses;

  always #5 clk = ~clk;

  bcd_ndigit_counter_if #(.NDIGITS(4)) m_if ();
  bcd_ndigit_counter_if #(.NDIGITS(2)) lo_if ();
  bcd_ndigit_counter_if #(.NDIGITS(2)) hi_if ();

  bcd_ndigit_counter #(.NDIGITS(4), .RST_VAL(0)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (m_if.slave)
  );

  bcd_ndigit_counter #(.NDIGITS(2), .RST_VAL(0)) u_lo (
    .clk  (clk),
    .rstn (rstn),
    .bus  (lo_if.slave)
  );

  bcd_ndigit_counter #(.NDIGITS(2), .RST_VAL(0)) u_hi (
    .clk  (clk),
    .rstn (rstn),
    .bus  (hi_if.slave)
  );

  assign hi_if.count = lo_if.tc;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [15:0] v);
    m_if.din  = v;
    m_if.load = 1'b1;
    cyc();
    m_if.load = 1'b0;
  endtask

  initial begin
    m_if.mode   = 1'b1;
    m_if.count  = 1'b0;
    m_if.clr    = 1'b0;
    m_if.load   = 1'b0;
    m_if.din    = '0;
    lo_if.mode  = 1'b1;
    lo_if.count = 1'b0;
    lo_if.clr   = 1'b0;
    lo_if.load  = 1'b0;
    lo_if.din   = '0;
    hi_if.mode  = 1'b1;
    hi_if.clr   = 1'b0;
    hi_if.load  = 1'b0;
    hi_if.din   = '0;
`ifdef BCD_MODULO_LIMIT_EN
    m_if.limit  = 16'h9999;
    lo_if.limit = 8'h99;
    hi_if.limit = 8'h99;
`endif
    #12;
    chk("rst_q",   32'(m_if.Q),   32'h0);
    chk("rst_err", 32'(m_if.err), 32'h0);
    chk("rst_tc",  32'(m_if.tc),  32'h0);
    @(negedge clk);
    rstn = 1'b0;
    cyc();

    // illegal load then count to 0357, reset mid-count
    ld(16'h03A0);
    chk("ld03A0_q",   32'(m_if.Q),   32'h0300);
    chk("ld03A0_err", 32'(m_if.err), 32'h1);
    m_if.mode  = 1'b1;
    m_if.count = 1'b1;
    repeat (57) cyc();
    chk("pre_rst_q", 32'(m_if.Q), 32'h0357);
    #3 rstn = 1'b1;
    #1;
    chk("async_rst_q",   32'(m_if.Q),   32'h0);
    chk("async_rst_err", 32'(m_if.err), 32'h0);
    m_if.count = 1'b0;
    rstn = 1'b0;
    cyc();

    // up wrap
    ld(16'h9998);
    m_if.mode  = 1'b1;
    m_if.count = 1'b1;
    #1 chk("up_tc_9998", 32'(m_if.tc), 32'h0);
    cyc();
    chk("up_q_9999", 32'(m_if.Q), 32'h9999);
    chk("up_tc_9999", 32'(m_if.tc), 32'h1);
    cyc();
    chk("up_q_0000", 32'(m_if.Q), 32'h0000);
    chk("up_tc_0000", 32'(m_if.tc), 32'h0);
    m_if.count = 1'b0;
    chk("hold_tc", 32'(m_if.tc), 32'h0);
    cyc();
    chk("hold_q", 32'(m_if.Q), 32'h0000);

    // down borrow
    ld(16'h1000);
    m_if.mode  = 1'b0;
    m_if.count = 1'b1;
    cyc();
    chk("dn_q_0999", 32'(m_if.Q), 32'h0999);
    m_if.count = 1'b0;
    ld(16'h0000);
    m_if.count = 1'b1;
    #1 chk("dn_tc_0000", 32'(m_if.tc), 32'h1);
    cyc();
    chk("dn_q_9999", 32'(m_if.Q), 32'h9999);
    chk("dn_tc_9999", 32'(m_if.tc), 32'h0);
    m_if.count = 1'b0;

    // illegal load, sticky err, clear
    ld(16'h12A4);
    chk("ill_q",   32'(m_if.Q),   32'h1204);
    chk("ill_err", 32'(m_if.err), 32'h1);
    m_if.mode  = 1'b1;
    m_if.count = 1'b1;
    repeat (10) cyc();
    m_if.count = 1'b0;
    chk("ill_cnt_q",   32'(m_if.Q),   32'h1214);
    chk("ill_cnt_err", 32'(m_if.err), 32'h1);
    m_if.clr = 1'b1;
    cyc();
    m_if.clr = 1'b0;
    chk("clr_q",   32'(m_if.Q),   32'h0);
    chk("clr_err", 32'(m_if.err), 32'h0);

    // priority clr > load > count
    ld(16'h0042);
    m_if.clr   = 1'b1;
    m_if.load  = 1'b1;
    m_if.count = 1'b1;
    m_if.din   = 16'h0777;
    cyc();
    m_if.clr = 1'b0;
    chk("pri_clr_q", 32'(m_if.Q), 32'h0000);
    m_if.mode = 1'b0;
    #1 chk("pri_ld_tc", 32'(m_if.tc), 32'h0);
    cyc();
    m_if.load  = 1'b0;
    m_if.count = 1'b0;
    chk("pri_ld_q", 32'(m_if.Q), 32'h0777);

`ifdef BCD_MODULO_LIMIT_EN
    m_if.limit = 16'h0059;
    ld(16'h0058);
    m_if.mode  = 1'b1;
    m_if.count = 1'b1;
    #1 chk("lim_tc_58", 32'(m_if.tc), 32'h0);
    cyc();
    chk("lim_q_59",  32'(m_if.Q),  32'h0059);
    chk("lim_tc_59", 32'(m_if.tc), 32'h1);
    cyc();
    chk("lim_q_00", 32'(m_if.Q), 32'h0000);
    m_if.mode = 1'b0;
    cyc();
    chk("lim_dn_q", 32'(m_if.Q), 32'h0059);
    m_if.count = 1'b0;
    ld(16'h0070);
    chk("lim_ld_q",   32'(m_if.Q),   32'h0059);
    chk("lim_ld_err", 32'(m_if.err), 32'h1);
    m_if.clr = 1'b1;
    cyc();
    m_if.clr   = 1'b0;
    m_if.limit = 16'h00F0;
    cyc();
    chk("lim_bad_err", 32'(m_if.err), 32'h1);
    m_if.limit = 16'h9999;
    m_if.clr = 1'b1;
    cyc();
    m_if.clr = 1'b0;
`endif

    // cascade: two 2-digit counters, 10000 clocks
    hi_pulses   = 0;
    lo_pulses   = 0;
    lo_if.count = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if (hi_if.tc) hi_pulses++;
      if (lo_if.tc) lo_pulses++;
      if (i == 5678)
        chk("casc_mid", 32'({hi_if.Q, lo_if.Q}),
            32'h5678);
      cyc();
    end
    lo_if.count = 1'b0;
    chk("casc_q", 32'({hi_if.Q, lo_if.Q}), 32'h0000);
    chk("casc_hi_tc", 32'(hi_pulses), 32'd1);
    chk("casc_lo_tc", 32'(lo_pulses), 32'd100);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
